order_arbiter: RTL and testbench

ORDER_ARBITER -- requirements
Module: order_arbiter

---
 rtl/order_pkg.sv | 22 ++
 rtl/req_hold_reg.sv | 30 +++
 rtl/order_arbiter.sv | 151 +++++++++++++++
 tb/tb_order_arbiter.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/order_pkg.sv
// Shared types and widths for the order arbiter and its request holding registers.
package order_pkg;

   localparam int CLIENT_ID_W   = 5;
   localparam int AMOUNT_W      = 32;
   localparam int EXCH_AMOUNT_W = 16;

   localparam int CPU_REQ_W  = 1 + CLIENT_ID_W + AMOUNT_W;
   localparam int EXCH_REQ_W = CLIENT_ID_W + EXCH_AMOUNT_W;

   typedef enum logic [1:0] {
      ST_IDLE      = 2'd0,
      ST_ISSUE     = 2'd1,
      ST_WAIT_DONE = 2'd2
   } state_t;

   typedef enum logic {
      SRC_CPU  = 1'b0,
      SRC_EXCH = 1'b1
   } src_t;

endpackage

// File: rtl/req_hold_reg.sv
// Single-entry holding register: captures a request when empty and holds it until granted.
module req_hold_reg #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         HRESETn,
   input  logic         go,
   input  logic [W-1:0] data_in,
   input  logic         clr,
   output logic         pending,
   output logic         ready,
   output logic [W-1:0] data_out
);

   // clr takes priority, so a go on the clearing edge still sees ready=0 and is dropped.
   always_ff @(posedge clk or negedge HRESETn) begin
      if (!HRESETn) begin
         pending  <= 1'b0;
         data_out <= '0;
      end else if (clr) begin
         pending  <= 1'b0;
      end else if (go && !pending) begin
         pending  <= 1'b1;
         data_out <= data_in;
      end
   end

   assign ready = !pending;

endmodule

// File: rtl/order_arbiter.sv
// Arbitrates CPU and exchange requests onto the shared client table with
// round-robin tie-breaking and a tbl_done watchdog.
//
// state        | meaning
// ST_IDLE      | waiting for a pending request; picks a winner and loads tbl_*
// ST_ISSUE     | tbl_valid high, fields frozen until tbl_ready
// ST_WAIT_DONE | table busy; waiting for tbl_done or timeout
module order_arbiter
   import order_pkg::*;
#(
   parameter int TIMEOUT_CYC = 16
) (
   input  logic                     clk,
   input  logic                     HRESETn,
   input  logic                     cpu_go,
   input  logic                     cpu_new_max,
   input  logic [CLIENT_ID_W-1:0]   cpu_client_id,
   input  logic [AMOUNT_W-1:0]      cpu_amount,
   output logic                     cpu_ready,
   input  logic                     exchange_go,
   input  logic [CLIENT_ID_W-1:0]   exchange_client_id,
   input  logic [EXCH_AMOUNT_W-1:0] exchange_amount,
   output logic                     exchange_ready,
   output logic                     tbl_valid,
   input  logic                     tbl_ready,
   output logic                     tbl_src,
   output logic                     tbl_new_max,
   output logic [CLIENT_ID_W-1:0]   tbl_client_id,
   output logic [AMOUNT_W-1:0]      tbl_amount,
   input  logic                     tbl_done,
   output logic                     timeout_err,
   output logic [15:0]              grant_cnt_cpu,
   output logic [15:0]              grant_cnt_exch
);

   localparam int TMR_W = $clog2(TIMEOUT_CYC + 1);
   localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYC - 1);

   state_t                   state;
   src_t                     last_src;
   src_t                     tbl_src_q;
   logic [TMR_W-1:0]         timer;

   logic                     cpu_pending;
   logic                     exch_pending;
   logic [CPU_REQ_W-1:0]     cpu_data;
   logic [EXCH_REQ_W-1:0]    exch_data;

   logic                     cpu_q_new_max;
   logic [CLIENT_ID_W-1:0]   cpu_q_id;
   logic [AMOUNT_W-1:0]      cpu_q_amount;
   logic [CLIENT_ID_W-1:0]   exch_q_id;
   logic [EXCH_AMOUNT_W-1:0] exch_q_amount;

   logic                     handshake;
   logic                     clr_cpu;
   logic                     clr_exch;
   logic                     pick_exch;

   req_hold_reg #(.W(CPU_REQ_W)) u_cpu_hold (
      .clk      (clk),
      .HRESETn  (HRESETn),
      .go       (cpu_go),
      .data_in  ({cpu_new_max, cpu_client_id, cpu_amount}),
      .clr      (clr_cpu),
      .pending  (cpu_pending),
      .ready    (cpu_ready),
      .data_out (cpu_data)
   );

   req_hold_reg #(.W(EXCH_REQ_W)) u_exch_hold (
      .clk      (clk),
      .HRESETn  (HRESETn),
      .go       (exchange_go),
      .data_in  ({exchange_client_id, exchange_amount}),
      .clr      (clr_exch),
      .pending  (exch_pending),
      .ready    (exchange_ready),
      .data_out (exch_data)
   );

   assign {cpu_q_new_max, cpu_q_id, cpu_q_amount} = cpu_data;
   assign {exch_q_id, exch_q_amount}              = exch_data;

   assign handshake = tbl_valid && tbl_ready;
   assign clr_cpu   = handshake && (tbl_src_q == SRC_CPU);
   assign clr_exch  = handshake && (tbl_src_q == SRC_EXCH);

   // On a tie the side that did not win last time goes next.
   assign pick_exch = exch_pending && (!cpu_pending || (last_src == SRC_CPU));

   assign tbl_src = tbl_src_q;

   always_ff @(posedge clk or negedge HRESETn) begin
      if (!HRESETn) begin
         state          <= ST_IDLE;
         last_src       <= SRC_CPU;
         tbl_src_q      <= SRC_CPU;
         tbl_valid      <= 1'b0;
         tbl_new_max    <= 1'b0;
         tbl_client_id  <= '0;
         tbl_amount     <= '0;
         timer          <= '0;
         timeout_err    <= 1'b0;
         grant_cnt_cpu  <= '0;
         grant_cnt_exch <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (cpu_pending || exch_pending) begin
                  state     <= ST_ISSUE;
                  tbl_valid <= 1'b1;
                  if (pick_exch) begin
                     tbl_src_q     <= SRC_EXCH;
                     tbl_new_max   <= 1'b0;
                     tbl_client_id <= exch_q_id;
                     tbl_amount    <= {{(AMOUNT_W - EXCH_AMOUNT_W){1'b0}}, exch_q_amount};
                  end else begin
                     tbl_src_q     <= SRC_CPU;
                     tbl_new_max   <= cpu_q_new_max;
                     tbl_client_id <= cpu_q_id;
                     tbl_amount    <= cpu_q_amount;
                  end
               end
            end
            ST_ISSUE: begin
               if (tbl_ready) begin
                  state     <= ST_WAIT_DONE;
                  tbl_valid <= 1'b0;
                  last_src  <= tbl_src_q;
                  timer     <= '0;
                  if (tbl_src_q == SRC_EXCH) grant_cnt_exch <= grant_cnt_exch + 16'd1;
                  else                       grant_cnt_cpu  <= grant_cnt_cpu + 16'd1;
               end
            end
            ST_WAIT_DONE: begin
               if (tbl_done) begin
                  state <= ST_IDLE;
               end else if (timer == TMR_LAST) begin
                  state       <= ST_IDLE;
                  timeout_err <= 1'b1;
               end else begin
                  timer <= timer + 1'b1;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_order_arbiter.sv
// Directed self-checking bench for order_arbiter with hand-computed expectations.
module tb_order_arbiter;

   logic        clk = 1'b0;
   logic        HRESETn;
   logic        cpu_go;
   logic        cpu_new_max;
   logic [4:0]  cpu_client_id;
   logic [31:0] cpu_amount;
   logic        cpu_ready;
   logic        exchange_go;
   logic [4:0]  exchange_client_id;
   logic [15:0] exchange_amount;
   logic        exchange_ready;
   logic        tbl_valid;
   logic        tbl_ready;
   logic        tbl_src;
   logic        tbl_new_max;
   logic [4:0]  tbl_client_id;
   logic [31:0] tbl_amount;
   logic        tbl_done;
   logic        timeout_err;
   logic [15:0] grant_cnt_cpu;
   logic [15:0] grant_cnt_exch;

   int n_checks = 0;
   int n_fail   = 0;

   order_arbiter #(.TIMEOUT_CYC(16)) dut (
      .clk                (clk),
      .HRESETn            (HRESETn),
      .cpu_go             (cpu_go),
      .cpu_new_max        (cpu_new_max),
      .cpu_client_id      (cpu_client_id),
      .cpu_amount         (cpu_amount),
      .cpu_ready          (cpu_ready),
      .exchange_go        (exchange_go),
      .exchange_client_id (exchange_client_id),
      .exchange_amount    (exchange_amount),
      .exchange_ready     (exchange_ready),
      .tbl_valid          (tbl_valid),
      .tbl_ready          (tbl_ready),
      .tbl_src            (tbl_src),
      .tbl_new_max        (tbl_new_max),
      .tbl_client_id      (tbl_client_id),
      .tbl_amount         (tbl_amount),
      .tbl_done           (tbl_done),
      .timeout_err        (timeout_err),
      .grant_cnt_cpu      (grant_cnt_cpu),
      .grant_cnt_exch     (grant_cnt_exch)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic pulse_done();
      tbl_done = 1'b1;
      tick();
      tbl_done = 1'b0;
   endtask

   task automatic check_idle_outputs(input string tag);
      chk({tag, "_valid"},   32'(tbl_valid), 32'd0);
      chk({tag, "_amount"},  tbl_amount, 32'd0);
      chk({tag, "_id"},      32'(tbl_client_id), 32'd0);
      chk({tag, "_src"},     32'(tbl_src), 32'd0);
      chk({tag, "_tmo"},     32'(timeout_err), 32'd0);
      chk({tag, "_cnt_cpu"}, 32'(grant_cnt_cpu), 32'd0);
      chk({tag, "_cnt_ex"},  32'(grant_cnt_exch), 32'd0);
      chk({tag, "_cpu_rdy"}, 32'(cpu_ready), 32'd1);
      chk({tag, "_ex_rdy"},  32'(exchange_ready), 32'd1);
   endtask

   initial begin
      HRESETn = 1'b0;
      cpu_go = 0; cpu_new_max = 0; cpu_client_id = 0; cpu_amount = 0;
      exchange_go = 0; exchange_client_id = 0; exchange_amount = 0;
      tbl_ready = 1'b1;
      tbl_done = 1'b0;
      repeat (3) tick();
      check_idle_outputs("rst");
      HRESETn = 1'b1;
      tick();

      // Single CPU request, tbl_valid two cycles after go
      cpu_go = 1; cpu_client_id = 5'd3; cpu_amount = 32'd100; cpu_new_max = 0;
      tick();
      cpu_go = 0;
      chk("t1_cpu_rdy_low", 32'(cpu_ready), 32'd0);
      chk("t1_valid_n1", 32'(tbl_valid), 32'd0);
      tick();
      chk("t1_valid_n2", 32'(tbl_valid), 32'd1);
      chk("t1_src", 32'(tbl_src), 32'd0);
      chk("t1_id", 32'(tbl_client_id), 32'd3);
      chk("t1_amount", tbl_amount, 32'd100);
      tick();
      chk("t1_valid_drop", 32'(tbl_valid), 32'd0);
      chk("t1_cnt_cpu", 32'(grant_cnt_cpu), 32'd1);
      chk("t1_cpu_rdy_back", 32'(cpu_ready), 32'd1);
      pulse_done();

      // Ties: exchange wins while last_src is CPU
      for (int r = 0; r < 2; r++) begin
         cpu_go = 1; cpu_client_id = 5'd1; cpu_amount = 32'd11;
         exchange_go = 1; exchange_client_id = 5'd2; exchange_amount = 16'd22;
         tick();
         cpu_go = 0; exchange_go = 0;
         tick();
         chk("tie_first_valid", 32'(tbl_valid), 32'd1);
         chk("tie_first_src", 32'(tbl_src), 32'd1);
         chk("tie_first_id", 32'(tbl_client_id), 32'd2);
         chk("tie_first_amount", tbl_amount, 32'd22);
         tick();
         chk("tie_cnt_exch", 32'(grant_cnt_exch), 32'(1 + r));
         chk("tie_ex_rdy", 32'(exchange_ready), 32'd1);
         chk("tie_cpu_rdy", 32'(cpu_ready), 32'd0);
         pulse_done();
         chk("tie_idle_gap", 32'(tbl_valid), 32'd0);
         tick();
         chk("tie_second_valid", 32'(tbl_valid), 32'd1);
         chk("tie_second_src", 32'(tbl_src), 32'd0);
         chk("tie_second_id", 32'(tbl_client_id), 32'd1);
         tick();
         chk("tie_cnt_cpu", 32'(grant_cnt_cpu), 32'(2 + r));
         pulse_done();
      end

      // Backpressure: fields frozen, second go ignored
      tbl_ready = 1'b0;
      cpu_go = 1; cpu_client_id = 5'd7; cpu_amount = 32'hDEAD_BEEF; cpu_new_max = 1;
      tick();
      cpu_go = 0; cpu_new_max = 0;
      tick();
      for (int i = 0; i < 5; i++) begin
         chk("bp_valid", 32'(tbl_valid), 32'd1);
         chk("bp_id", 32'(tbl_client_id), 32'd7);
         chk("bp_amount", tbl_amount, 32'hDEAD_BEEF);
         chk("bp_new_max", 32'(tbl_new_max), 32'd1);
         chk("bp_cpu_rdy", 32'(cpu_ready), 32'd0);
         if (i == 1) begin
            cpu_go = 1; cpu_client_id = 5'd20; cpu_amount = 32'd555;
         end
         tick();
         cpu_go = 0;
      end
      chk("bp_id_end", 32'(tbl_client_id), 32'd7);
      tbl_ready = 1'b1;
      tick();
      chk("bp_cnt_cpu", 32'(grant_cnt_cpu), 32'd4);
      chk("bp_cpu_rdy_back", 32'(cpu_ready), 32'd1);
      pulse_done();
      tick();
      tick();
      chk("bp_no_second_grant", 32'(tbl_valid), 32'd0);
      chk("bp_cnt_cpu_hold", 32'(grant_cnt_cpu), 32'd4);

      // Timeout after 16 cycles in WAIT_DONE, then pending exchange granted
      cpu_go = 1; cpu_client_id = 5'd4; cpu_amount = 32'd44;
      tick();
      cpu_go = 0;
      tick();
      tick();
      chk("to_cnt_cpu", 32'(grant_cnt_cpu), 32'd5);
      exchange_go = 1; exchange_client_id = 5'd12; exchange_amount = 16'h1234;
      tick();
      exchange_go = 0;
      repeat (14) tick();
      chk("to_not_yet", 32'(timeout_err), 32'd0);
      chk("to_no_grant_yet", 32'(tbl_valid), 32'd0);
      tick();
      chk("to_err_set", 32'(timeout_err), 32'd1);
      tick();
      chk("to_exch_valid", 32'(tbl_valid), 32'd1);
      chk("to_exch_src", 32'(tbl_src), 32'd1);
      chk("to_exch_amount", tbl_amount, 32'h0000_1234);
      tick();
      chk("to_cnt_exch", 32'(grant_cnt_exch), 32'd3);
      pulse_done();
      chk("to_err_sticky", 32'(timeout_err), 32'd1);

      // Exchange zero-extension, then reset in WAIT_DONE
      exchange_go = 1; exchange_client_id = 5'd9; exchange_amount = 16'hFFFF;
      tick();
      exchange_go = 0;
      tick();
      chk("zx_valid", 32'(tbl_valid), 32'd1);
      chk("zx_src", 32'(tbl_src), 32'd1);
      chk("zx_new_max", 32'(tbl_new_max), 32'd0);
      chk("zx_id", 32'(tbl_client_id), 32'd9);
      chk("zx_amount", tbl_amount, 32'h0000_FFFF);
      tick();
      chk("zx_cnt_exch", 32'(grant_cnt_exch), 32'd4);
      #2;
      HRESETn = 1'b0;
      #1;
      check_idle_outputs("arst");
      tick();
      HRESETn = 1'b1;
      tick();

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
